parity_share_arbiter: RTL and testbench
=======================================

# parity_share_arbiter

Shares one combinational 8-bit parity unit (`parity_using_assign`) between two requesting channels. Each channel submits a byte plus its expected parity bit over a valid/ready handshake. The block arbitrates round-robin, computes parity on a registered copy of the winning byte, and returns the parity, a mismatch flag and the channel id over a response handshake. It keeps one saturating mismatch counter per channel and sits between the byte sources and the error-reporting logic.

## Interface
- `ODD` — default 0 — 0: even parity (`rsp_parity` = XOR of the data bits); 1: odd parity (inverted XOR).
- `ERR_CNT_W` — default 8 — width of each mismatch counter.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `req_valid` input 2 — bit i: channel i has a request.
- `req_ready` output 2 — bit i: channel i's request is accepted this cycle.
- `req_data0` input 8 — channel 0 byte.
- `req_data1` input 8 — channel 1 byte.
- `req_par` input 2 — bit i: expected parity for channel i.
- `rsp_valid` output 1 — response is available.
- `rsp_ready` input 1 — consumer takes the response.
- `rsp_id` output 1 — channel that owns the response.
- `rsp_parity` output 1 — computed parity.
- `rsp_err` output 1 — computed parity differs from the expected parity.
- `clr_cnt` input 1 — synchronous clear of both counters.
- `err_cnt0` output ERR_CNT_W — channel 0 mismatch count.
- `err_cnt1` output ERR_CNT_W — channel 1 mismatch count.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, grant one channel. With both set, grant the channel ≠ `last_id`. With one set, grant that channel.
  - `req_ready[g]` = 1, combinational, in IDLE only; the other bit is 0.
  - On the grant edge, capture the data, the expected bit and `g` into `hold_*`, then go to CALC.
- CALC:
  - The shared parity unit evaluates `hold_data`.
  - Register `rsp_parity` = parity XOR `ODD` and `rsp_err` = (`rsp_parity` ≠ `hold_exp`), then go to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_id`, `rsp_parity` and `rsp_err` stay stable.
  - On `rsp_valid` && `rsp_ready`: set `last_id` ← `rsp_id`, increment `err_cntN` if `rsp_err`, go to IDLE.
- Counters:
  - Saturate at all-ones; no wrap.
  - `clr_cnt` zeroes both counters and overrides a same-cycle increment.
- `req_valid` dropping during CALC or RESP has no effect; the captured request completes.
- No request is accepted outside IDLE.
- Reset mid-operation: the in-flight request is discarded and not reported.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_parity` = 0, `rsp_err` = 0.
  - `err_cnt0` = 0, `err_cnt1` = 0.
  - `last_id` = 1, so that channel 0 wins the first contested grant.

## Timing
- Accept at edge N (IDLE with `req_ready` high). CALC during cycle N+1. `rsp_valid` is high from cycle N+2.
- Minimum spacing between accepts is 3 cycles (IDLE → CALC → RESP → IDLE).
- The earliest next `req_ready` comes the cycle after the response handshake.
- A counter update is visible on the cycle after the response handshake.
- `rsp_*` are registered outputs. `req_ready` is a decode of state and `req_valid`; it has no path from `rsp_ready`.

## Structure
- Shared package `parity_pkg` holds:
  - the state enum (IDLE/CALC/RESP);
  - `PARITY_W` = 8;
  - the channel-count constant `N_CH` = 2.
- Sub-module: one instance of `parity_using_assign` (`data_in` = `hold_data`, `parity_out` → CALC logic). It is the only parity instance.
- The arbiter pointer and counters stay inline. No further sub-modules.

## Test plan
- Reset release, then ch0 sends 8'h03 with `req_par`=0 (`ODD`=0) → `rsp_valid` 2 cycles after accept; `rsp_parity`=0, `rsp_err`=0, `rsp_id`=0; `err_cnt0` stays 0.
- ch1 sends 8'h01 with `req_par`=0 → `rsp_parity`=1, `rsp_err`=1, `rsp_id`=1; `err_cnt1`=1 the cycle after handshake.
- Both channels hold valid continuously (ch0 8'hAA, ch1 8'hFF) → grants alternate 0,1,0,1 starting with ch0; each accept is ≥3 cycles apart.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready`=00 throughout; handshake on cycle 6 → IDLE.
- `ERR_CNT_W`=2, 5 mismatching ch0 requests → `err_cnt0` reads 1,2,3,3,3. Assert `clr_cnt` on the same cycle as the 6th mismatch handshake → 0.
- Assert `rst_n`=0 while in CALC → all outputs return to reset values immediately. After release no stale response appears, and the first contested grant goes to ch0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity-sharing arbiter slice.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned PARITY_W = 8;
  localparam int unsigned N_CH     = 2;

endpackage

// File: rtl/parity_using_assign.sv
// Combinational even-parity reduction over one byte; the single shared parity unit.
module parity_using_assign
  import parity_pkg::*;
(
  input  logic [PARITY_W-1:0] data_in,
  output logic                parity_out
);

  assign parity_out = ^data_in;

endmodule

// File: rtl/parity_share_arbiter.sv
// Two-channel round-robin front end sharing one parity unit, with registered
// response handshake and per-channel saturating mismatch counters.
module parity_share_arbiter
  import parity_pkg::*;
#(
  parameter bit          ODD       = 1'b0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req_valid,
  output logic [N_CH-1:0]      req_ready,
  input  logic [PARITY_W-1:0]  req_data0,
  input  logic [PARITY_W-1:0]  req_data1,
  input  logic [N_CH-1:0]      req_par,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic                 rsp_parity,
  output logic                 rsp_err,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt0,
  output logic [ERR_CNT_W-1:0] err_cnt1
);

  state_e                state_q, state_d;
  logic                  last_id_q, last_id_d;
  logic [PARITY_W-1:0]   hold_data_q, hold_data_d;
  logic                  hold_exp_q, hold_exp_d;
  logic                  hold_id_q, hold_id_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  rsp_parity_q, rsp_parity_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [ERR_CNT_W-1:0]  cnt1_q, cnt1_d;

  logic                  any_req;
  logic                  grant;
  logic                  par_raw;
  logic                  par_adj;

  parity_using_assign u_parity (
    .data_in    (hold_data_q),
    .parity_out (par_raw)
  );

  assign any_req = |req_valid;
  // Contested requests go to the channel that was not served last.
  assign grant   = (req_valid == 2'b11) ? ~last_id_q : req_valid[1];
  assign par_adj = par_raw ^ ODD;

  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    hold_data_d  = hold_data_q;
    hold_exp_d   = hold_exp_q;
    hold_id_d    = hold_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_parity_d = rsp_parity_q;
    rsp_err_d    = rsp_err_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready   = grant ? 2'b10 : 2'b01;
          hold_data_d = grant ? req_data1 : req_data0;
          hold_exp_d  = req_par[grant];
          hold_id_d   = grant;
          state_d     = CALC;
        end
      end
      CALC: begin
        rsp_parity_d = par_adj;
        rsp_err_d    = (par_adj != hold_exp_q);
        rsp_id_d     = hold_id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_id_d = rsp_id_q;
          if (rsp_err_q) begin
            if (rsp_id_q) begin
              cnt1_d = (cnt1_q == '1) ? cnt1_q : cnt1_q + ERR_CNT_W'(1);
            end else begin
              cnt0_d = (cnt0_q == '1) ? cnt0_q : cnt0_q + ERR_CNT_W'(1);
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over an increment landing on the same edge.
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;
      hold_data_q  <= '0;
      hold_exp_q   <= 1'b0;
      hold_id_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_parity_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      hold_data_q  <= hold_data_d;
      hold_exp_q   <= hold_exp_d;
      hold_id_q    <= hold_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_err_q    <= rsp_err_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_parity = rsp_parity_q;
  assign rsp_err    = rsp_err_q;
  assign err_cnt0   = cnt0_q;
  assign err_cnt1   = cnt1_q;

endmodule

// File: tb/tb_parity_share_arbiter.sv
// Directed scoreboard bench for parity_share_arbiter (ODD=0, 2-bit counters).
module tb_parity_share_arbiter;

  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [7:0]   req_data0 = 8'h00;
  logic [7:0]   req_data1 = 8'h00;
  logic [1:0]   req_par = 2'b00;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic         rsp_parity;
  logic         rsp_err;
  logic         clr_cnt = 1'b0;
  logic [W-1:0] err_cnt0;
  logic [W-1:0] err_cnt1;

  parity_share_arbiter #(.ODD(1'b0), .ERR_CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_par    (req_par),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_parity (rsp_parity),
    .rsp_err    (rsp_err),
    .clr_cnt    (clr_cnt),
    .err_cnt0   (err_cnt0),
    .err_cnt1   (err_cnt1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic        par;
    logic        err;
    int unsigned rise;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: response latency on rise, payload on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (rsp_valid && !prev_rv) begin
        chk("rsp_has_expectation", sb.size() != 0, 1);
        if (sb.size() != 0) chk("rsp_latency", cyc, sb[0].rise);
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_id", rsp_id, mon_e.id);
        chk("rsp_parity", rsp_parity, mon_e.par);
        chk("rsp_err", rsp_err, mon_e.err);
      end
      prev_rv = rsp_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic ch, input logic [7:0] data, input logic par,
                       input logic ep, input logic ee);
    int g;
    if (ch) req_data1 = data; else req_data0 = data;
    req_par[ch] = par;
    req_valid   = ch ? 2'b10 : 2'b01;
    g = 0;
    while (g < 20) begin
      #1;
      if (req_ready[ch]) begin
        sb.push_back(exp_t'{id: ch, par: ep, err: ee, rise: cyc + 2});
        @(posedge clk); #1;
        req_valid = 2'b00;
        break;
      end
      @(posedge clk); #1;
      g++;
    end
    chk("issue_accepted", g < 20, 1);
    req_valid = 2'b00;
  endtask

  task automatic wait_hs(input logic do_clr);
    int g;
    g = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("handshake_seen", rsp_valid && rsp_ready, 1);
    clr_cnt = do_clr;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  // Both channels held valid; AA and FF both have even parity, so par 0 / err 0.
  task automatic contested(input int n_acc);
    int          n, guard;
    logic        exp_ch;
    int unsigned last_acc;
    req_data0 = 8'hAA;
    req_data1 = 8'hFF;
    req_par   = 2'b00;
    req_valid = 2'b11;
    exp_ch    = 1'b0;
    last_acc  = 0;
    n = 0;
    guard = 0;
    while (n < n_acc && guard < 100) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("grant_order", req_ready, exp_ch ? 2'b10 : 2'b01);
        if (n != 0) chk("accept_gap_ge3", (cyc - last_acc) >= 3, 1);
        sb.push_back(exp_t'{id: exp_ch, par: 1'b0, err: 1'b0, rise: cyc + 2});
        last_acc = cyc;
        exp_ch   = ~exp_ch;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("contested_accepts", n, n_acc);
    req_valid = 2'b00;
  endtask

  initial begin
    int g;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_parity", rsp_parity, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cnt0", err_cnt0, 0);
    chk("rst_cnt1", err_cnt1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8'h03 has two ones -> even parity 0, matches expected.
    issue(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    wait_hs(1'b0);
    chk("cnt0_after_good", err_cnt0, 0);

    // 8'h01 -> parity 1 vs expected 0: mismatch.
    issue(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_hs(1'b0);
    chk("cnt1_after_err", err_cnt1, 1);

    contested(4);
    wait_hs(1'b0);

    // Backpressure: 8'h07 -> parity 1, expected 1.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h07, 1'b1, 1'b1, 1'b0);
    g = 0;
    while (!rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("stall_rsp_valid_seen", rsp_valid, 1);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_parity", rsp_parity, 1);
      chk("stall_err", rsp_err, 0);
      chk("stall_req_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_hs(1'b0);
    chk("idle_after_stall", rsp_valid, 0);

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_cnt0", err_cnt0, 0);
    chk("clr_cnt1", err_cnt1, 0);

    // Saturation of 2-bit counter: 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
      wait_hs(1'b0);
      chk("sat_cnt0", err_cnt0, (i < 3) ? i + 1 : 3);
    end
    issue(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_hs(1'b1);
    chk("clr_beats_inc", err_cnt0, 0);

    // Leave last_id = 0 and cnt1 = 1 before the mid-CALC reset.
    issue(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_hs(1'b0);
    chk("pre_rst_cnt1", err_cnt1, 1);
    issue(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    wait_hs(1'b0);

    issue(1'b0, 8'h07, 1'b0, 1'b1, 1'b1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 2'b00);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_rsp_parity", rsp_parity, 0);
    chk("midrst_rsp_err", rsp_err, 0);
    chk("midrst_cnt1", err_cnt1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    contested(2);
    wait_hs(1'b0);

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
